// File: rtl/banco_pkg.sv
// Shared definitions for the register bank and its initiator-side sequencer.
package banco_pkg;

    localparam int unsigned BANCO_ADDR_W    = 5;
    localparam int unsigned BANCO_DATA_W    = 32;
    localparam int unsigned BANCO_ZERO_ADDR = 0;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWrite = 3'd1,
        StRdRs  = 3'd2,
        StRdRt  = 3'd3,
        StCap   = 3'd4,
        StDone  = 3'd5
    } seq_state_e;

endpackage

// File: rtl/banco.sv
// Single-ported register bank: one address, synchronous write, registered read data.
module banco import banco_pkg::*; #(
    parameter int unsigned DATA_W = BANCO_DATA_W,
    parameter int unsigned ADDR_W = BANCO_ADDR_W
) (
    input  logic              clock,
    input  logic [ADDR_W-1:0] address,
    input  logic              enable_write,
    input  logic              enable_read,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] out_data
);

    localparam int unsigned Depth = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [Depth];

    always_ff @(posedge clock) begin
        if (enable_write) begin
            regs_q[address] <= in_data;
        end
        if (enable_read) begin
            out_data <= regs_q[address];
        end
    end

endmodule

// File: rtl/banco_seq.sv
// Serialises one write-back plus up to two operand reads onto the single-ported bank
// and returns the operands through a valid/ready response.
module banco_seq import banco_pkg::*; #(
    parameter int unsigned DATA_W   = BANCO_DATA_W,
    parameter int unsigned ADDR_W   = BANCO_ADDR_W,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              rt_en,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [ADDR_W-1:0] bank_address,
    output logic              bank_enable_write,
    output logic              bank_enable_read,
    output logic [DATA_W-1:0] bank_in_data,
    input  logic [DATA_W-1:0] bank_out_data
);

    localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(BANCO_ZERO_ADDR);

    seq_state_e        state_q;
    logic [ADDR_W-1:0] rs_q;
    logic [ADDR_W-1:0] rt_q;
    logic [ADDR_W-1:0] rd_q;
    logic              rt_en_q;
    logic [DATA_W-1:0] wb_data_q;

    function automatic logic [DATA_W-1:0] operand(input logic [ADDR_W-1:0] addr,
                                                   input logic [DATA_W-1:0] data);
        if (ZERO_REG && addr == ZeroAddr) begin
            return '0;
        end
        return data;
    endfunction

    assign req_ready = (state_q == StIdle) && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            rt_en_q   <= 1'b0;
            wb_data_q <= '0;
            rs_data   <= '0;
            rt_data   <= '0;
            rsp_valid <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        rs_q      <= rs_addr;
                        rt_q      <= rt_addr;
                        rd_q      <= rd_addr;
                        rt_en_q   <= rt_en;
                        wb_data_q <= wb_data;
                        // Writes to the hardwired zero register are dropped outright.
                        if (wb_en && !(ZERO_REG && rd_addr == ZeroAddr)) begin
                            state_q <= StWrite;
                        end else begin
                            state_q <= StRdRs;
                        end
                    end
                end
                StWrite: state_q <= StRdRs;
                StRdRs:  state_q <= rt_en_q ? StRdRt : StCap;
                StRdRt: begin
                    // Bank data now holds the rs read issued last cycle.
                    rs_data <= operand(rs_q, bank_out_data);
                    state_q <= StCap;
                end
                StCap: begin
                    if (rt_en_q) begin
                        rt_data <= operand(rt_q, bank_out_data);
                    end else begin
                        rs_data <= operand(rs_q, bank_out_data);
                        rt_data <= '0;
                    end
                    rsp_valid <= 1'b1;
                    state_q   <= StDone;
                end
                StDone: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Gated by reset so an aborted request never touches the bank.
    always_comb begin
        bank_address      = '0;
        bank_enable_write = 1'b0;
        bank_enable_read  = 1'b0;
        bank_in_data      = '0;
        if (!reset) begin
            case (state_q)
                StWrite: begin
                    bank_address      = rd_q;
                    bank_enable_write = 1'b1;
                    bank_in_data      = wb_data_q;
                end
                StRdRs: begin
                    bank_address     = rs_q;
                    bank_enable_read = 1'b1;
                end
                StRdRt: begin
                    bank_address     = rt_q;
                    bank_enable_read = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_banco_seq.sv
// Directed bench for banco_seq driving a real banco: vector table plus stall/reset sequences.
module tb_banco_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rt_en;
    logic        wb_en;
    logic [4:0]  rd_addr;
    logic [31:0] wb_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  bank_address;
    logic        bank_enable_write;
    logic        bank_enable_read;
    logic [31:0] bank_in_data;
    logic [31:0] bank_out_data;

    int total  = 0;
    int passed = 0;
    int wr_count = 0;
    logic both_seen = 1'b0;

    always #5 clock = ~clock;

    banco_seq dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .rs_addr           (rs_addr),
        .rt_addr           (rt_addr),
        .rt_en             (rt_en),
        .wb_en             (wb_en),
        .rd_addr           (rd_addr),
        .wb_data           (wb_data),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rs_data           (rs_data),
        .rt_data           (rt_data),
        .bank_address      (bank_address),
        .bank_enable_write (bank_enable_write),
        .bank_enable_read  (bank_enable_read),
        .bank_in_data      (bank_in_data),
        .bank_out_data     (bank_out_data)
    );

    banco bank (
        .clock        (clock),
        .address      (bank_address),
        .enable_write (bank_enable_write),
        .enable_read  (bank_enable_read),
        .in_data      (bank_in_data),
        .out_data     (bank_out_data)
    );

    always @(posedge clock) begin
        if (bank_enable_write) wr_count <= wr_count + 1;
        if (bank_enable_write && bank_enable_read) both_seen <= 1'b1;
    end

    typedef struct {
        logic        wb_en;
        logic [4:0]  rd;
        logic [31:0] wb_data;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        rt_en;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
        int          lat;
        int          wr;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int w0;
        int lat;
        w0 = wr_count;
        @(negedge clock);
        wb_en = v.wb_en; rd_addr = v.rd; wb_data = v.wb_data;
        rs_addr = v.rs; rt_addr = v.rt; rt_en = v.rt_en; req_valid = 1'b1;
        chk($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'd1);
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clock);
            #1 lat++;
        end
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d rs_data", idx), rs_data, v.exp_rs);
        chk($sformatf("v%0d rt_data", idx), rt_data, v.exp_rt);
        chk($sformatf("v%0d bank writes", idx), 32'(wr_count - w0), 32'(v.wr));
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
        chk($sformatf("v%0d rsp one cycle", idx), 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        logic        seen;
        int          w0;

        // {wb_en, rd, wb_data, rs, rt, rt_en, exp_rs, exp_rt, lat, writes}
        vecs[0]  = '{1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd0, 1'b0, 32'hDEADBEEF, 32'h0, 3, 1};
        vecs[1]  = '{1'b1, 5'd5, 32'h11111111, 5'd5, 5'd0, 1'b0, 32'h11111111, 32'h0, 3, 1};
        vecs[2]  = '{1'b1, 5'd6, 32'h22222222, 5'd6, 5'd0, 1'b0, 32'h22222222, 32'h0, 3, 1};
        vecs[3]  = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b1, 32'h11111111, 32'h22222222, 3, 0};
        vecs[4]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, 3, 0};
        vecs[5]  = '{1'b1, 5'd7, 32'h12345678, 5'd7, 5'd3, 1'b1, 32'h12345678, 32'hDEADBEEF, 4, 1};
        vecs[6]  = '{1'b0, 5'd0, 32'h0, 5'd3, 5'd6, 1'b0, 32'hDEADBEEF, 32'h0, 2, 0};
        vecs[7]  = '{1'b1, 5'd8, 32'hCAFEF00D, 5'd5, 5'd8, 1'b1, 32'h11111111, 32'hCAFEF00D, 4, 1};
        vecs[8]  = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 1'b1, 32'h0, 32'h11111111, 3, 0};
        vecs[9]  = '{1'b1, 5'd9, 32'hA5A5A5A5, 5'd3, 5'd0, 1'b0, 32'hDEADBEEF, 32'h0, 3, 1};
        vecs[10] = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 32'hA5A5A5A5, 32'h0, 2, 0};

        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        rs_addr = '0; rt_addr = '0; rt_en = 1'b0; wb_en = 1'b0; rd_addr = '0; wb_data = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("req_ready in reset", 32'(req_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rs_data", rs_data, 32'h0);
        chk("reset rt_data", rt_data, 32'h0);
        chk("reset bank enables", 32'({bank_enable_write, bank_enable_read}), 32'd0);

        // Vectors run back-to-back: each request issues right after the prior handshake.
        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Stall in DONE with a stray request offered.
        w0 = wr_count;
        @(negedge clock);
        wb_en = 1'b0; rs_addr = 5'd6; rt_en = 1'b0; req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 held = rs_data;
        chk("stall first rsp_valid", 32'(rsp_valid), 32'd1);
        chk("stall rs_data", held, 32'h22222222);
        seen = 1'b0;
        wb_en = 1'b1; rd_addr = 5'd6; wb_data = 32'h0BAD0BAD; rs_addr = 5'd3; req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (!rsp_valid || rs_data !== held || rt_data !== 32'h0 || req_ready) seen = 1'b1;
        end
        req_valid = 1'b0;
        chk("stall outputs stable", 32'(seen), 32'd0);
        chk("stall no bank write", 32'(wr_count - w0), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
        chk("stall release rsp_valid", 32'(rsp_valid), 32'd0);
        chk("stall release req_ready", 32'(req_ready), 32'd1);

        // Reset during the WRITE cycle of a write to r7.
        w0 = wr_count;
        @(negedge clock);
        wb_en = 1'b1; rd_addr = 5'd7; wb_data = 32'hFFFF0000; rs_addr = 5'd7; rt_en = 1'b0;
        req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0; reset = 1'b1;
        #1;
        chk("abort enable_write", 32'(bank_enable_write), 32'd0);
        chk("abort bank_address", 32'(bank_address), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("abort req_ready", 32'(req_ready), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock);
            #1 if (rsp_valid) seen = 1'b1;
        end
        chk("abort no response", 32'(seen), 32'd0);
        chk("abort no bank write", 32'(wr_count - w0), 32'd0);
        run_vec(11, '{1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 32'h12345678, 32'h0, 2, 0});

        chk("enables never both", 32'(both_seen), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
